// File: rtl/instruction_decode_pkg.sv
// rtl/instruction_decode_pkg.sv - shared opcode, NOP, ALU-code and immediate helpers for pipeline stages
package instruction_decode_pkg;

    localparam logic [6:0]  OP_R    = 7'b0110011;
    localparam logic [6:0]  OP_I    = 7'b0010011;
    localparam logic [6:0]  OP_LW   = 7'b0000011;
    localparam logic [6:0]  OP_SW   = 7'b0100011;
    localparam logic [6:0]  OP_BR   = 7'b1100011;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rd;
        alu_ctrl_e   alu_ctrl;
        logic        alu_src;
        logic        reg_write;
        logic        mem_write;
        logic        result_src;
        logic        branch;
    } idex_t;

    function automatic logic [31:0] imm_i(input logic [31:0] w);
        return {{20{w[31]}}, w[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] w);
        return {{20{w[31]}}, w[31:25], w[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] w);
        return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/instruction_decode_register_file.sv
// rtl/instruction_decode_register_file.sv - 32x32 register file, two async read ports, one sync write port
// Ports: clk, rst (sync active-low), we/waddr/wdata (write port),
//        raddr1/raddr2 -> rdata1/rdata2 (combinational reads, write-first bypass, x0 reads 0).
module register_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    // A same-cycle write-back wins over the stored value so decode sees fresh data.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != 5'd0) begin
            rdata1 = (we && (waddr == raddr1)) ? wdata : regs_q[raddr1];
        end
        if (raddr2 != 5'd0) begin
            rdata2 = (we && (waddr == raddr2)) ? wdata : regs_q[raddr2];
        end
    end

endmodule

// File: rtl/instruction_decode.sv
// rtl/instruction_decode.sv - IF/ID register, decode logic, ID/EX register and register file
// Ports: clk, rst (sync active-low); inst, flush from fetch; wbWe/wbRd/wbData write-back;
//        branchFlag/zeroFlag/branchOffset to fetch; rd1, rd2, immExt, rd, aluCtrl, aluSrc,
//        regWrite, memWrite, resultSrc, valid, illegal to execute.
module instruction_decode
    import instruction_decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        flush,
    input  logic        wbWe,
    input  logic [4:0]  wbRd,
    input  logic [31:0] wbData,
    output logic        branchFlag,
    output logic        zeroFlag,
    output logic [31:0] branchOffset,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] immExt,
    output logic [4:0]  rd,
    output logic [2:0]  aluCtrl,
    output logic        aluSrc,
    output logic        regWrite,
    output logic        memWrite,
    output logic        resultSrc,
    output logic        valid,
    output logic        illegal
);

    logic [31:0] ifid_inst_q;
    logic        ifid_valid_q;
    idex_t       idex_q;
    idex_t       idex_d;
    idex_t       dec;
    logic        legal;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    assign opcode = ifid_inst_q[6:0];
    assign funct3 = ifid_inst_q[14:12];
    assign funct7 = ifid_inst_q[31:25];

    register_file u_register_file (
        .clk    (clk),
        .rst    (rst),
        .we     (wbWe),
        .waddr  (wbRd),
        .wdata  (wbData),
        .raddr1 (ifid_inst_q[19:15]),
        .raddr2 (ifid_inst_q[24:20]),
        .rdata1 (rf_rd1),
        .rdata2 (rf_rd2)
    );

    always_comb begin
        dec     = '0;
        legal   = 1'b0;
        dec.rd1 = rf_rd1;
        dec.rd2 = rf_rd2;
        case (opcode)
            OP_R: begin
                dec.rd        = ifid_inst_q[11:7];
                dec.reg_write = 1'b1;
                legal         = 1'b1;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: dec.alu_ctrl = ALU_ADD;
                    {7'b0100000, 3'b000}: dec.alu_ctrl = ALU_SUB;
                    {7'b0000000, 3'b111}: dec.alu_ctrl = ALU_AND;
                    {7'b0000000, 3'b110}: dec.alu_ctrl = ALU_OR;
                    {7'b0000000, 3'b010}: dec.alu_ctrl = ALU_SLT;
                    default:              legal        = 1'b0;
                endcase
            end
            OP_I: begin
                dec.rd        = ifid_inst_q[11:7];
                dec.imm       = imm_i(ifid_inst_q);
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                legal         = 1'b1;
                case (funct3)
                    3'b000:  dec.alu_ctrl = ALU_ADD;
                    3'b111:  dec.alu_ctrl = ALU_AND;
                    3'b110:  dec.alu_ctrl = ALU_OR;
                    3'b010:  dec.alu_ctrl = ALU_SLT;
                    default: legal        = 1'b0;
                endcase
            end
            OP_LW: begin
                dec.rd         = ifid_inst_q[11:7];
                dec.imm        = imm_i(ifid_inst_q);
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = 1'b1;
                legal          = (funct3 == 3'b010);
            end
            OP_SW: begin
                dec.imm       = imm_s(ifid_inst_q);
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                legal         = (funct3 == 3'b010);
            end
            OP_BR: begin
                dec.imm      = imm_b(ifid_inst_q);
                dec.branch   = 1'b1;
                dec.alu_ctrl = ALU_SUB;
                legal        = (funct3 == 3'b000);
            end
            default: legal = 1'b0;
        endcase

        // Flush beats everything; an empty IF/ID slot is a bubble, not an illegal.
        idex_d = '0;
        if (!flush && ifid_valid_q) begin
            if (legal) begin
                idex_d       = dec;
                idex_d.valid = 1'b1;
            end else begin
                idex_d.illegal = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ifid_inst_q  <= NOP_INST;
            ifid_valid_q <= 1'b0;
            idex_q       <= '0;
        end else begin
            if (flush) begin
                ifid_inst_q  <= NOP_INST;
                ifid_valid_q <= 1'b0;
            end else begin
                ifid_inst_q  <= inst;
                ifid_valid_q <= 1'b1;
            end
            idex_q <= idex_d;
        end
    end

    assign rd1          = idex_q.rd1;
    assign rd2          = idex_q.rd2;
    assign immExt       = idex_q.imm;
    assign rd           = idex_q.rd;
    assign aluCtrl      = idex_q.alu_ctrl;
    assign aluSrc       = idex_q.alu_src;
    assign regWrite     = idex_q.reg_write;
    assign memWrite     = idex_q.mem_write;
    assign resultSrc    = idex_q.result_src;
    assign valid        = idex_q.valid;
    assign illegal      = idex_q.illegal;
    assign branchFlag   = idex_q.branch;
    assign branchOffset = idex_q.imm;
    assign zeroFlag     = idex_q.valid && (idex_q.rd1 == idex_q.rd2);

endmodule

// File: tb/tb_instruction_decode.sv
// tb/tb_instruction_decode.sv - randomized self-checking bench for instruction_decode
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst = 32'h0000_0013;
    logic        flush = 1'b0;
    logic        wbWe = 1'b0;
    logic [4:0]  wbRd = '0;
    logic [31:0] wbData = '0;
    logic        branchFlag, zeroFlag, valid, illegal;
    logic        aluSrc, regWrite, memWrite, resultSrc;
    logic [31:0] branchOffset, rd1, rd2, immExt;
    logic [4:0]  rd;
    logic [2:0]  aluCtrl;

    int checks = 0;
    int failures = 0;

    instruction_decode dut (
        .clk(clk), .rst(rst), .inst(inst), .flush(flush),
        .wbWe(wbWe), .wbRd(wbRd), .wbData(wbData),
        .branchFlag(branchFlag), .zeroFlag(zeroFlag), .branchOffset(branchOffset),
        .rd1(rd1), .rd2(rd2), .immExt(immExt), .rd(rd), .aluCtrl(aluCtrl),
        .aluSrc(aluSrc), .regWrite(regWrite), .memWrite(memWrite),
        .resultSrc(resultSrc), .valid(valid), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [2:0]  alu;
        logic        alu_src;
        logic        reg_write;
        logic        mem_write;
        logic        result_src;
        logic        branch;
        logic        zero;
        logic [31:0] offset;
    } outs_t;

    // ---------------- reference model ----------------
    logic [31:0] m_regs [32];
    logic [31:0] m_ifid;
    logic        m_ifid_v;
    outs_t       m_exp;
    bit          model_ok = 0;

    function automatic logic [31:0] sx(input int value);
        return 32'(value);
    endfunction

    function automatic outs_t model_decode(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
        outs_t o;
        int f3, f7, opc, ii, is, ib;
        bit ok;
        o = '0;
        ok = 0;
        f3 = int'(w[14:12]);
        f7 = int'(w[31:25]);
        opc = int'(w[6:0]);
        ii = int'($signed(w)) >>> 20;
        is = ((int'($signed(w)) >>> 25) * 32) + int'(w[11:7]);
        ib = ((int'($signed(w)) >>> 31) * 4096) + int'(w[7]) * 2048
             + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        if (opc == 'h33) begin
            o.rd = w[11:7]; o.reg_write = 1; ok = 1;
            if (f7 == 0 && f3 == 0) o.alu = 3'd0;
            else if (f7 == 'h20 && f3 == 0) o.alu = 3'd1;
            else if (f7 == 0 && f3 == 7) o.alu = 3'd2;
            else if (f7 == 0 && f3 == 6) o.alu = 3'd3;
            else if (f7 == 0 && f3 == 2) o.alu = 3'd5;
            else ok = 0;
        end else if (opc == 'h13) begin
            o.rd = w[11:7]; o.reg_write = 1; o.alu_src = 1; o.imm = sx(ii); ok = 1;
            if (f3 == 0) o.alu = 3'd0;
            else if (f3 == 7) o.alu = 3'd2;
            else if (f3 == 6) o.alu = 3'd3;
            else if (f3 == 2) o.alu = 3'd5;
            else ok = 0;
        end else if (opc == 'h03) begin
            o.rd = w[11:7]; o.reg_write = 1; o.alu_src = 1; o.result_src = 1;
            o.imm = sx(ii); ok = (f3 == 2);
        end else if (opc == 'h23) begin
            o.mem_write = 1; o.alu_src = 1; o.imm = sx(is); ok = (f3 == 2);
        end else if (opc == 'h63) begin
            o.branch = 1; o.alu = 3'd1; o.imm = sx(ib); ok = (f3 == 0);
        end
        if (!ok) begin
            o = '0;
            o.illegal = 1;
        end else begin
            o.valid = 1;
            o.rd1 = a;
            o.rd2 = b;
            o.zero = (a == b);
            o.offset = o.imm;
        end
        return o;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 0) return 32'd0;
        if (wbWe && wbRd == r) return wbData;
        return m_regs[r];
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_ifid = 32'h13;
            m_ifid_v = 0;
            m_exp = '0;
            model_ok = 1;
        end else if (model_ok) begin
            if (flush || !m_ifid_v) m_exp = '0;
            else m_exp = model_decode(m_ifid, m_read(m_ifid[19:15]), m_read(m_ifid[24:20]));
            if (wbWe && wbRd != 0) m_regs[wbRd] = wbData;
            m_ifid = flush ? 32'h13 : inst;
            m_ifid_v = !flush;
        end
    end

    function automatic outs_t dut_outs();
        outs_t o;
        o.valid = valid; o.illegal = illegal; o.rd1 = rd1; o.rd2 = rd2; o.imm = immExt;
        o.rd = rd; o.alu = aluCtrl; o.alu_src = aluSrc; o.reg_write = regWrite;
        o.mem_write = memWrite; o.result_src = resultSrc; o.branch = branchFlag;
        o.zero = zeroFlag; o.offset = branchOffset;
        return o;
    endfunction

    // Per-cycle compare of every output against the model.
    always @(posedge clk) begin
        #1;
        if (model_ok) begin
            checks++;
            if (dut_outs() !== m_exp) begin
                failures++;
                $display("FAIL pipe t=%0t actual=%h required=%h", $time, dut_outs(), m_exp);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        int sel;
        w = $urandom;
        sel = $urandom_range(0, 9);
        case (sel)
            0, 1: begin
                w[6:0] = 7'h33;
                w[31:25] = ($urandom_range(0, 3) == 0) ? 7'h20 : (($urandom_range(0, 5) == 0) ? w[31:25] : 7'h00);
            end
            2, 3: w[6:0] = 7'h13;
            4: begin w[6:0] = 7'h03; if ($urandom_range(0, 3) != 0) w[14:12] = 3'b010; end
            5: begin w[6:0] = 7'h23; if ($urandom_range(0, 3) != 0) w[14:12] = 3'b010; end
            6, 7: begin
                w[6:0] = 7'h63;
                if ($urandom_range(0, 3) != 0) w[14:12] = 3'b000;
                if ($urandom_range(0, 1) == 0) w[24:20] = w[19:15];
            end
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        // Reset held for two edges.
        rst = 0;
        tick(); tick();
        check("reset_outs", {valid, illegal, regWrite, memWrite, branchFlag, zeroFlag, aluSrc, resultSrc, aluCtrl},
              32'd0);
        check("reset_data", rd1 | rd2 | immExt | branchOffset | {27'd0, rd}, 32'd0);
        rst = 1;

        // x1..x31 read 0 after reset.
        for (int i = 1; i < 32; i++) begin
            inst = {7'd0, 5'(i), 5'(i), 3'b000, 5'd0, 7'h33};
            tick(); tick();
            check("reg_zero", rd1 | rd2, 32'd0);
        end

        // addi x1,x0,5
        inst = 32'h0050_0093; tick();
        inst = 32'h13; tick();
        check("addi_fields", {valid, regWrite, aluSrc, aluCtrl, rd}, {1'b1, 1'b1, 1'b1, 3'b000, 5'd1});
        check("addi_imm", immExt, 32'd5);

        // beq x1,x2,8 with x2=7 already and x1=7 arriving by write-back bypass.
        inst = 32'h0020_8463; wbWe = 1; wbRd = 2; wbData = 7; tick();
        inst = 32'h13; wbRd = 1; tick();
        wbWe = 0;
        check("beq_bypass_flags", {branchFlag, zeroFlag}, 2'b11);
        check("beq_bypass_off", branchOffset, 32'd8);

        // beq x0,x0,-4
        inst = 32'hFE00_0EE3; tick();
        inst = 32'h13; tick();
        check("beq_neg_off", branchOffset, 32'hFFFF_FFFC);
        check("beq_neg_zero", {branchFlag, zeroFlag}, 2'b11);

        // Flush with an add in IF/ID.
        inst = 32'h0020_81B3; tick();
        flush = 1; tick();
        flush = 0;
        check("flush_bubble", {valid, regWrite, illegal}, 3'b000);
        inst = 32'h0050_0093; tick(); tick();
        inst = 32'h13;
        check("after_flush", {valid, regWrite, rd}, {1'b1, 1'b1, 5'd1});

        // Illegal opcode: one-cycle pulse with bubble.
        inst = 32'h0000_007F; tick();
        inst = 32'h13; tick();
        check("illegal_pulse", {illegal, valid, regWrite}, 3'b100);
        tick();
        check("illegal_clear", {illegal, valid}, 2'b01);

        // Illegal opcode coincident with flush, at input and in IF/ID.
        inst = 32'h0000_007F; flush = 1; tick();
        flush = 0; inst = 32'h13; tick();
        check("illegal_flush_in", {illegal, valid}, 2'b00);
        inst = 32'h0000_007F; tick();
        inst = 32'h13; flush = 1; tick();
        flush = 0;
        check("illegal_flush_ifid", {illegal, valid}, 2'b00);

        // Write-back during a flush still lands.
        inst = 32'h13; flush = 1; wbWe = 1; wbRd = 5'd9; wbData = 32'hA5A5_0001; tick();
        flush = 0; wbWe = 0; inst = {7'd0, 5'd9, 5'd9, 3'b000, 5'd0, 7'h33}; tick(); tick();
        check("wb_in_flush", rd1, 32'hA5A5_0001);

        // Mid-run reset clears everything, including registers.
        inst = 32'h0020_81B3; wbWe = 1; wbRd = 5'd3; wbData = 32'h1234; flush = 1; rst = 0; tick();
        rst = 1; wbWe = 0; flush = 0; inst = {7'd0, 5'd3, 5'd9, 3'b000, 5'd0, 7'h33};
        check("midrun_reset", {valid, illegal, regWrite, branchFlag}, 4'd0);
        tick(); tick();
        check("midrun_reset_regs", rd1 | rd2, 32'd0);

        // Randomized traffic checked every cycle against the model.
        for (int n = 0; n < 4000; n++) begin
            inst   = rand_inst();
            flush  = ($urandom_range(0, 9) == 0);
            wbWe   = ($urandom_range(0, 1) == 0);
            wbRd   = 5'($urandom_range(0, 31));
            wbData = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            rst    = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst = 1; flush = 0; wbWe = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1; reset is synchronous and active-low.
REQ-003 SHALL have port inst, input, 32, the instruction word from the fetch stage.
REQ-004 SHALL have port flush, input, 1, high while the fetch stage redirects on a taken branch.
REQ-005 SHALL have WB write ports: wbWe (input, 1, write enable), wbRd (input, 5, destination register), wbData (input, 32, write data).
REQ-006 SHALL have fetch-feedback outputs: branchFlag (output, 1), zeroFlag (output, 1), branchOffset (output, 32).
REQ-007 SHALL have ID/EX outputs:
- rd1, rd2 (output, 32): source register values.
- immExt (output, 32): extended immediate.
- rd (output, 5): destination register.
- aluCtrl (output, 3): ALU operation.
- aluSrc, regWrite, memWrite, resultSrc (output, 1 each): datapath controls.
- valid (output, 1): stage holds a real instruction.
- illegal (output, 1): unsupported opcode seen.

Function
REQ-008 SHALL register inst in an IF/ID register (instruction and valid bit) on each edge; the register is loaded with NOP 0x00000013 and valid=0 when flush=1.
REQ-009 SHALL decode the IF/ID contents combinationally and capture the results in an ID/EX register on the next edge; inst to ID/EX outputs latency is 2 edges.
REQ-010 SHALL load the ID/EX register with a bubble when flush=1: valid=0, regWrite=0, memWrite=0, branchFlag=0, all data fields 0.
REQ-011 SHALL support the following opcodes:
- 0110011 R-type: add, sub, and, or, slt.
- 0010011 I-type: addi, andi, ori, slti.
- 0000011 lw.
- 0100011 sw.
- 1100011 with funct3=000 (beq).
REQ-012 SHALL encode aluCtrl as ADD=000, SUB=001, AND=010, OR=011, SLT=101; beq uses SUB.
REQ-013 SHALL sign-extend immediates from bit 31 using the I, S and B formats; the B-type immediate has bit 0 forced to 0.
REQ-014 SHALL drive control signals per class:
- lw: regWrite=1, aluSrc=1, resultSrc=1.
- sw: memWrite=1, aluSrc=1, regWrite=0.
- beq: branchFlag=1, regWrite=0.
REQ-015 SHALL, for any other opcode or funct3 combination, load a bubble into ID/EX and set illegal=1 for exactly that one cycle.
REQ-016 SHALL drive branchOffset = immExt and zeroFlag = (rd1 == rd2) from the ID/EX register; both are 0 when ID/EX holds a bubble.
REQ-017 SHALL include a 32x32 register file with two combinational read ports (rs1=inst[19:15], rs2=inst[24:20]) and one synchronous write port.
REQ-018 SHALL always read x0 as 0 and ignore writes to x0.
REQ-019 SHALL bypass WB data to a read port (write-first) when wbWe=1, wbRd equals that source register, and wbRd != 0.
REQ-020 SHALL give flush priority over a simultaneous illegal decode: no illegal pulse is raised for a flushed instruction.
REQ-021 SHALL perform WB writes even during flush cycles.

Reset
REQ-022 SHALL, with rst=0 at an edge, set IF/ID to NOP with valid=0 and set every ID/EX output, including illegal, to 0.
REQ-023 SHALL clear all 32 registers to 0 on reset.
REQ-024 SHALL let reset override flush, WB writes and the pipeline contents when asserted mid-operation.

Structure
REQ-025 SHALL take opcode constants, the NOP encoding and the aluCtrl codes from a shared package used by all pipeline stages.
REQ-026 SHALL implement the register file as the sub-module register_file; decode logic and the pipeline registers stay in instruction_decode.

Verification
REQ-027 Reset: hold rst=0 for 2 edges -> all outputs 0; registers x1..x31 read 0.
REQ-028 addi x1,x0,5 (0x00500093) -> 2 edges later: valid=1, immExt=5, rd=1, regWrite=1, aluSrc=1, aluCtrl=000.
REQ-029 Branch with bypass:
- Stimulus: wbWe=1, wbRd=1, wbData=7 in the same cycle beq x1,x2,8 (0x00208463) sits in IF/ID, with x2=7.
- Required response: branchFlag=1, zeroFlag=1, branchOffset=8.
REQ-030 beq x0,x0,-4 (0xFE000EE3) -> branchOffset=0xFFFFFFFC, zeroFlag=1.
REQ-031 Flush: assert flush=1 for one cycle while an add is in IF/ID -> next ID/EX has valid=0, regWrite=0; the following instruction decodes normally.
REQ-032 Illegal instruction: inst=0x0000007F -> illegal=1 for one cycle with a bubble in ID/EX; the same opcode coincident with flush=1 -> illegal stays 0.
